// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 access codes and defaults for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int TIMEOUT_CYCLES_DEF = 16;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: data-memory request/ready bus between the load/store unit (master) and memory (slave)
interface lsu_if #(parameter int AW = 32);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_ready, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane steering, byte enables, load extraction/extension and access legality checks
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic [3:0]  be,
    output logic        misalign,
    output logic        illegal
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b          = rdata[{addr_lo, 3'b000} +: 8];
        h          = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        illegal    = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (is_store && funct3[2]);
        misalign   = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3 == F3_W && addr_lo != 2'b00);
        wdata_lane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        be         = (!is_store || funct3[1]) ? 4'hf :
                     funct3[0] ? (addr_lo[1] ? 4'hc : 4'h3) : 4'b0001 << addr_lo;
        rdata_ext  = funct3 == F3_B  ? {{24{b[7]}}, b} :
                     funct3 == F3_BU ? {24'b0, b} :
                     funct3 == F3_H  ? {{16{h[15]}}, h} :
                     funct3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store stage with memory handshake; LSU_TIMEOUT_EN adds a REQ watchdog
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALUout,
    input  logic [DATA_WIDTH-1:0] regOp2,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] RD,
    lsu_if.master                 mem
);
    state_t                    state, nxt;
    logic                      we_q, fault_q, to, idle;
    logic [2:0]                f3_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wd_q, wd_s, ext;
    logic [3:0]                be_q, be_s;
    logic                      misalign, illegal;
    assign idle = state == IDLE;
    // In IDLE the helper checks the incoming request; afterwards it decodes the latched one.
    lsu_align u_align (
        .addr_lo   (idle ? ALUout[1:0] : addr_q[1:0]),
        .funct3    (idle ? funct3 : f3_q),
        .is_store  (idle ? MemWrite : we_q),
        .wdata     (regOp2),
        .rdata     (mem.mem_rdata),
        .wdata_lane(wd_s),
        .rdata_ext (ext),
        .be        (be_s),
        .misalign  (misalign),
        .illegal   (illegal)
    );
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign to = cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        cnt <= (rst || state != REQ) ? '0 : cnt + 1'b1;
`else
    assign to = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            RD      <= '0;
        end else begin
            state <= nxt;
            if (idle && start) begin
                we_q    <= MemWrite;
                f3_q    <= funct3;
                addr_q  <= ALUout[MEM_ADDR_WIDTH-1:0];
                wd_q    <= wd_s;
                be_q    <= be_s;
                fault_q <= misalign || illegal;
            end
            if (state == REQ && mem.mem_ready && !we_q)
                RD <= ext;
            if (state == REQ && !mem.mem_ready && to)
                fault_q <= 1'b1;
        end
    end
    always_comb begin
        nxt           = state;
        busy          = !idle;
        done          = state == DONE;
        fault         = state == DONE && fault_q;
        mem.mem_req   = state == REQ;
        mem.mem_we    = we_q;
        mem.mem_addr  = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
        mem.mem_wdata = wd_q;
        mem.mem_be    = be_q;
        if (idle && start)
            nxt = (misalign || illegal) ? DONE : REQ;
        else if (state == REQ && (mem.mem_ready || to))
            nxt = DONE;
        else if (state == DONE)
            nxt = IDLE;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst, start, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUout, regOp2, RD;
    logic        busy, done, fault;
    int          total = 0;
    int          passed = 0;
    lsu_if #(.AW(32)) mem ();
    load_store_unit dut (
        .clk(clk), .rst(rst), .start(start), .MemWrite(MemWrite), .funct3(funct3),
        .ALUout(ALUout), .regOp2(regOp2), .busy(busy), .done(done), .fault(fault),
        .RD(RD), .mem(mem)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1; MemWrite = we; funct3 = f3; ALUout = a; regOp2 = d;
        tick();
        start = 1'b0;
    endtask
    task automatic xfer(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] wd);
        issue(we, f3, a, d);
        chk({tag, "/req"}, 32'(mem.mem_req), 32'd1);
        chk({tag, "/addr"}, mem.mem_addr, {a[31:2], 2'b00});
        chk({tag, "/be"}, 32'(mem.mem_be), 32'(be));
        chk({tag, "/we"}, 32'(mem.mem_we), 32'(we));
        if (we) chk({tag, "/wdata"}, mem.mem_wdata, wd);
        mem.mem_ready = 1'b1; mem.mem_rdata = rdata;
        tick();
        mem.mem_ready = 1'b0; mem.mem_rdata = 32'h0;
        chk({tag, "/done"}, 32'(done), 32'd1);
        chk({tag, "/fault"}, 32'(fault), 32'd0);
        chk({tag, "/req_drop"}, 32'(mem.mem_req), 32'd0);
        tick();
        chk({tag, "/idle"}, {30'd0, busy, done}, 32'd0);
    endtask
    task automatic bad(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd_keep);
        issue(we, f3, a, 32'h11223344);
        chk({tag, "/req"}, 32'(mem.mem_req), 32'd0);
        chk({tag, "/done_fault"}, {30'd0, done, fault}, 32'd3);
        tick();
        chk({tag, "/idle"}, {29'd0, mem.mem_req, busy, done}, 32'd0);
        chk({tag, "/rd"}, RD, rd_keep);
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; MemWrite = 1'b0; funct3 = 3'b0; ALUout = '0; regOp2 = '0;
        mem.mem_ready = 1'b0; mem.mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst/ctl", {26'd0, busy, done, fault, mem.mem_req, mem.mem_we, 1'b0}, 32'd0);
        chk("rst/be", 32'(mem.mem_be), 32'd0);
        chk("rst/addr", mem.mem_addr, 32'd0);
        chk("rst/wdata", mem.mem_wdata, 32'd0);
        chk("rst/rd", RD, 32'd0);
        xfer("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 4'b1111, 32'hDEADBEEF);
        chk("sw/rd", RD, 32'd0);
        xfer("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 4'b1111, 32'h0);
        chk("lb/rd", RD, 32'hFFFFFF80);
        xfer("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 4'b1111, 32'h0);
        chk("lbu/rd", RD, 32'h00000080);
        xfer("sh", 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 4'b1100, 32'hABCDABCD);
        chk("sh/rd", RD, 32'h00000080);
        xfer("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 4'b1111, 32'h0);
        chk("lh/rd", RD, 32'hFFFF8001);
        xfer("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h80017FFF, 4'b1111, 32'h0);
        chk("lhu/rd", RD, 32'h00007FFF);
        xfer("sb", 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 4'b0010, 32'hA5A5A5A5);
        xfer("sh_lo", 1'b1, 3'b001, 32'h200, 32'h55661234, 32'h0, 4'b0011, 32'h12341234);
        xfer("lb_lane1", 1'b0, 3'b000, 32'h201, 32'h0, 32'hAABB7FCC, 4'b1111, 32'h0);
        chk("lb_lane1/rd", RD, 32'h0000007F);
        bad("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0000007F);
        bad("lh_mis", 1'b0, 3'b001, 32'h101, 32'h0000007F);
        bad("sbu_ill", 1'b1, 3'b100, 32'h100, 32'h0000007F);
        bad("f3_011", 1'b0, 3'b011, 32'h100, 32'h0000007F);
        bad("f3_110", 1'b1, 3'b110, 32'h100, 32'h0000007F);
        issue(1'b0, 3'b010, 32'h300, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("slow/req_c%0d", c), 32'(mem.mem_req), 32'd1);
            chk($sformatf("slow/addr_c%0d", c), mem.mem_addr, 32'h300);
            chk($sformatf("slow/bewe_c%0d", c), {27'd0, mem.mem_be, mem.mem_we}, 32'h1E);
            chk($sformatf("slow/nodone_c%0d", c), 32'(done), 32'd0);
            start = (c >= 2 && c <= 5); MemWrite = 1'b1; funct3 = 3'b000; ALUout = 32'h444; regOp2 = 32'hFF;
            if (c == 6) begin mem.mem_ready = 1'b1; mem.mem_rdata = 32'h12345678; end
            tick();
        end
        start = 1'b0; mem.mem_ready = 1'b0;
        chk("slow/done", {30'd0, done, fault}, 32'd2);
        chk("slow/rd", RD, 32'h12345678);
        tick();
        chk("slow/single", {29'd0, done, busy, mem.mem_req}, 32'd0);
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        tick();
        chk("rst_req/req_c2", 32'(mem.mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_req/ctl", {29'd0, mem.mem_req, busy, done}, 32'd0);
        chk("rst_req/rd", RD, 32'd0);
        tick();
        chk("rst_req/nodone", {30'd0, done, busy}, 32'd0);
        issue(1'b0, 3'b010, 32'h500, 32'h0);
`ifdef LSU_TIMEOUT_EN
        for (int c = 2; c <= 16; c++) tick();
        chk("wdog/req_c16", 32'(mem.mem_req), 32'd1);
        tick();
        chk("wdog/req_drop", 32'(mem.mem_req), 32'd0);
        chk("wdog/done_fault", {30'd0, done, fault}, 32'd3);
        chk("wdog/rd", RD, 32'd0);
        tick();
        chk("wdog/idle", 32'(busy), 32'd0);
`else
        for (int c = 2; c <= 30; c++) tick();
        chk("nowdog/req_c30", 32'(mem.mem_req), 32'd1);
        chk("nowdog/nodone", 32'(done), 32'd0);
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'hCAFEF00D;
        tick();
        mem.mem_ready = 1'b0;
        chk("nowdog/done", {30'd0, done, fault}, 32'd2);
        chk("nowdog/rd", RD, 32'hCAFEF00D);
        tick();
`endif
        xfer("after", 1'b0, 3'b010, 32'h600, 32'h0, 32'h0BADF00D, 4'b1111, 32'h0);
        chk("after/rd", RD, 32'h0BADF00D);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
